// File: rtl/tetris_pkg.sv
// Shared types for the TETRIS piece feeder: round length, sequencer states and the queued piece record.
package tetris_pkg;

  localparam logic [4:0] ROUND_LEN = 5'd16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DROP  = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] shape;
    logic [2:0] pos;
  } piece_t;

endpackage

// File: rtl/tetris_piece_fifo.sv
// Circular piece buffer between the host port and the sequencer.
// Flags are registered from the next occupancy; pointers wrap naturally on the power-of-two depth.
module tetris_piece_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [5:0] din,
  output logic [5:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [5:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Overflow and underflow are blocked here even if the caller misbehaves
  assign do_push_s = push & ~full_r;
  assign do_pop_s  = pop & ~empty_r;

  // Occupancy after this cycle's accepted push and pop
  always_comb begin
    count_nxt_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (do_pop_s && !do_push_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage, pointers and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 6'd0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == FULL_CNT);
      empty_r <= (count_nxt_s == '0);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/tetris_feeder.sv
// Piece sequencer feeding the TETRIS engine from a host FIFO: one piece per score cycle,
// 16-piece round tracking, discard of a failed round's remainder and an engine stall flag.
module tetris_feeder
  import tetris_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int GAP      = 1,
  parameter int MAX_WAIT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic [2:0] host_tetromino,
  input  logic [2:0] host_position,
  output logic       in_valid,
  output logic [2:0] tetrominoes,
  output logic [2:0] position,
  input  logic       score_valid,
  input  logic [3:0] score,
  input  logic       fail,
  input  logic       tetris_valid,
  output logic       round_done,
  output logic       round_fail,
  output logic [3:0] round_score,
  output logic       stall_err
);
  localparam int GW = $clog2(GAP + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  state_t        state_r;
  logic [4:0]    piece_cnt_r;
  logic [GW-1:0] gap_cnt_r;
  logic [WW-1:0] wait_cnt_r;
  logic          in_valid_r;
  logic [2:0]    tetromino_r;
  logic [2:0]    position_r;
  logic          round_done_r;
  logic          round_fail_r;
  logic [3:0]    round_score_r;
  logic          stall_err_r;
  piece_t        host_piece_s;
  piece_t        head_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_done_s;

  assign host_piece_s = '{shape: host_tetromino, pos: host_position};
  assign push_s       = host_valid & ~full_s;
  assign drop_done_s  = (piece_cnt_r == ROUND_LEN);
  // The issued piece leaves the FIFO during ISSUE; DROP discards one queued piece per cycle
  assign pop_s        = ~empty_s & ((state_r == ST_ISSUE) | ((state_r == ST_DROP) & ~drop_done_s));

  tetris_piece_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_s),
    .pop  (pop_s),
    .din  (host_piece_s),
    .dout (head_s),
    .full (full_s),
    .empty(empty_s)
  );

  // Sequencer FSM, round bookkeeping and registered engine-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      piece_cnt_r   <= 5'd0;
      gap_cnt_r     <= '0;
      wait_cnt_r    <= '0;
      in_valid_r    <= 1'b0;
      tetromino_r   <= 3'd0;
      position_r    <= 3'd0;
      round_done_r  <= 1'b0;
      round_fail_r  <= 1'b0;
      round_score_r <= 4'd0;
      stall_err_r   <= 1'b0;
    end else begin
      in_valid_r   <= 1'b0;
      tetromino_r  <= 3'd0;
      position_r   <= 3'd0;
      round_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            in_valid_r  <= 1'b1;
            tetromino_r <= head_s.shape;
            position_r  <= head_s.pos;
            state_r     <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          piece_cnt_r <= piece_cnt_r + 5'd1;
          wait_cnt_r  <= '0;
          state_r     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (score_valid) begin
            gap_cnt_r <= '0;
            state_r   <= ST_GAP;
            if (tetris_valid) begin
              round_fail_r  <= fail;
              round_score_r <= score;
              round_done_r  <= 1'b1;
              if (fail && (piece_cnt_r < ROUND_LEN)) begin
                state_r <= ST_DROP;
              end else begin
                piece_cnt_r <= 5'd0;
              end
            end
          end else if (wait_cnt_r == WAIT_LAST) begin
            stall_err_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            if (!empty_s) begin
              in_valid_r  <= 1'b1;
              tetromino_r <= head_s.shape;
              position_r  <= head_s.pos;
              state_r     <= ST_ISSUE;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        ST_DROP: begin
          if (drop_done_s) begin
            piece_cnt_r <= 5'd0;
            gap_cnt_r   <= '0;
            state_r     <= ST_GAP;
          end else if (!empty_s) begin
            piece_cnt_r <= piece_cnt_r + 5'd1;
          end else begin
            state_r <= ST_DROP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign host_ready  = ~full_s;
  assign in_valid    = in_valid_r;
  assign tetrominoes = tetromino_r;
  assign position    = position_r;
  assign round_done  = round_done_r;
  assign round_fail  = round_fail_r;
  assign round_score = round_score_r;
  assign stall_err   = stall_err_r;

endmodule

// File: tb/tb_tetris_feeder.sv
// Directed self-checking bench for tetris_feeder: issue timing, FIFO backpressure,
// round completion, failed-round discard, engine stall and asynchronous reset.
module tb_tetris_feeder;

  logic       clk;
  logic       rst_n;
  logic       host_valid;
  logic       host_ready;
  logic [2:0] host_tetromino;
  logic [2:0] host_position;
  logic       in_valid;
  logic [2:0] tetrominoes;
  logic [2:0] position;
  logic       score_valid;
  logic [3:0] score;
  logic       fail;
  logic       tetris_valid;
  logic       round_done;
  logic       round_fail;
  logic [3:0] round_score;
  logic       stall_err;

  int checks;
  int failures;
  int issue_count;

  tetris_feeder #(.DEPTH(4), .GAP(1), .MAX_WAIT(1000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .host_tetromino(host_tetromino),
    .host_position (host_position),
    .in_valid      (in_valid),
    .tetrominoes   (tetrominoes),
    .position      (position),
    .score_valid   (score_valid),
    .score         (score),
    .fail          (fail),
    .tetris_valid  (tetris_valid),
    .round_done    (round_done),
    .round_fail    (round_fail),
    .round_score   (round_score),
    .stall_err     (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count issue strobes in the low phase of the clock
  always begin
    @(negedge clk);
    #1;
    if (in_valid === 1'b1) issue_count++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [2:0] s, input logic [2:0] p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && host_ready !== 1'b1; i++) @(negedge clk);
    if (host_ready === 1'b1) begin
      host_valid = 1'b1;
      host_tetromino = s;
      host_position = p;
      @(negedge clk);
      host_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic wait_issue(output bit seen, output logic [2:0] s, output logic [2:0] p, output int n);
    seen = 1'b0; s = 3'd0; p = 3'd0; n = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      n = i + 1;
      if (in_valid === 1'b1) begin
        seen = 1'b1; s = tetrominoes; p = position;
      end
    end
  endtask

  task automatic pulse_score(input logic [3:0] sc, input logic f, input logic tv);
    @(negedge clk);
    score_valid = 1'b1; score = sc; fail = f; tetris_valid = tv;
    @(negedge clk);
    score_valid = 1'b0; score = 4'd0; fail = 1'b0; tetris_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_valid, tetrominoes, position, host_ready, round_done, round_fail, round_score, stall_err} !==
        {1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got iv=%b t=%0d p=%0d rdy=%b rd=%b rf=%b rs=%0d se=%b, want 0 0 0 1 0 0 0 0",
               in_valid, tetrominoes, position, host_ready, round_done, round_fail, round_score, stall_err);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_valid, host_ready, stall_err} !== 3'b010) begin
      failures++;
      $display("FAIL idle_after_reset: got iv=%b rdy=%b se=%b, want 0 1 0", in_valid, host_ready, stall_err);
    end
  endtask

  task automatic test_single();
    bit ok, seen, bad;
    logic [2:0] s, p;
    int n;
    push(3'd3, 3'd2, ok);
    wait_issue(seen, s, p, n);
    checks++;
    if (!seen || n != 1) begin
      failures++;
      $display("FAIL single_latency: seen=%0d ticks=%0d, want seen=1 ticks=1", seen, n);
    end
    checks++;
    if ({s, p} !== {3'd3, 3'd2}) begin
      failures++;
      $display("FAIL single_piece: got %0d/%0d, want 3/2", s, p);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_valid !== 1'b0 || tetrominoes !== 3'd0 || position !== 3'd0) bad = 1'b1;
    end
    push(3'd5, 3'd6, ok);
    if (in_valid !== 1'b0) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL single_once: extra strobe or nonzero data while waiting, want none");
    end
    pulse_score(4'd1, 1'b0, 1'b0);
    checks++;
    if (in_valid !== 1'b0) begin
      failures++;
      $display("FAIL gap_hold: in_valid=%b one cycle after score, want 0", in_valid);
    end
    wait_issue(seen, s, p, n);
    checks++;
    if (!seen || n > 2 || {s, p} !== {3'd5, 3'd6}) begin
      failures++;
      $display("FAIL gap_reissue: seen=%0d ticks=%0d piece=%0d/%0d, want seen=1 ticks<=2 piece=5/6", seen, n, s, p);
    end
    pulse_score(4'd2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp [7] = '{6'o11, 6'o27, 6'o40, 6'o65, 6'o03, 6'o71, 6'o34};
    bit ok, seen;
    logic [2:0] s, p;
    int n;
    push(exp[0][5:3], exp[0][2:0], ok);
    wait_issue(seen, s, p, n);
    checks++;
    if (!seen || {s, p} !== exp[0]) begin
      failures++;
      $display("FAIL b2b_first: seen=%0d piece=%o, want %o", seen, {s, p}, exp[0]);
    end
    for (int i = 1; i <= 4; i++) begin
      push(exp[i][5:3], exp[i][2:0], ok);
      checks++;
      if (host_ready !== (i < 4)) begin
        failures++;
        $display("FAIL ready_after_push%0d: got %b, want %b", i, host_ready, (i < 4));
      end
    end
    pulse_score(4'd0, 1'b0, 1'b0);
    wait_issue(seen, s, p, n);
    checks++;
    if (!seen || {s, p} !== exp[1]) begin
      failures++;
      $display("FAIL b2b_order1: seen=%0d piece=%o, want %o", seen, {s, p}, exp[1]);
    end
    push(exp[5][5:3], exp[5][2:0], ok);
    pulse_score(4'd0, 1'b0, 1'b0);
    wait_issue(seen, s, p, n);
    checks++;
    if (!seen || {s, p} !== exp[2] || host_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_order2_full: seen=%0d piece=%o rdy=%b, want %o rdy=0", seen, {s, p}, host_ready, exp[2]);
    end
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_pop: got %b, want 1", host_ready);
    end
    push(exp[6][5:3], exp[6][2:0], ok);
    pulse_score(4'd0, 1'b0, 1'b0);
    for (int i = 3; i <= 6; i++) begin
      wait_issue(seen, s, p, n);
      checks++;
      if (!seen || {s, p} !== exp[i]) begin
        failures++;
        $display("FAIL b2b_order%0d: seen=%0d piece=%o, want %o", i, seen, {s, p}, exp[i]);
      end
      pulse_score(4'd0, 1'b0, 1'b0);
    end
  endtask

  // Nine pieces of the current round are already played
  task automatic test_round();
    bit ok, seen;
    logic [2:0] s, p, es, ep;
    int n;
    for (int k = 10; k <= 16; k++) begin
      es = 3'(k % 8);
      ep = 3'((k * 3) % 8);
      push(es, ep, ok);
      wait_issue(seen, s, p, n);
      checks++;
      if (!seen || {s, p} !== {es, ep}) begin
        failures++;
        $display("FAIL round_piece%0d: seen=%0d piece=%0d/%0d, want %0d/%0d", k, seen, s, p, es, ep);
      end
      if (k == 16) pulse_score(4'd7, 1'b0, 1'b1);
      else pulse_score(4'd2, 1'b0, 1'b0);
    end
    checks++;
    if ({round_done, round_fail, round_score} !== {1'b1, 1'b0, 4'd7} || dut.piece_cnt_r !== 5'd0) begin
      failures++;
      $display("FAIL round_end: got rd=%b rf=%b rs=%0d cnt=%0d, want 1 0 7 0", round_done, round_fail, round_score, dut.piece_cnt_r);
    end
    @(negedge clk);
    checks++;
    if ({round_done, round_score} !== {1'b0, 4'd7}) begin
      failures++;
      $display("FAIL round_pulse_hold: got rd=%b rs=%0d, want 0 7", round_done, round_score);
    end
  endtask

  task automatic test_fail_drop();
    bit ok, seen;
    logic [2:0] s, p;
    int n, base;
    for (int k = 1; k <= 5; k++) begin
      push(3'(k + 1), 3'(7 - k), ok);
      wait_issue(seen, s, p, n);
      checks++;
      if (!seen || {s, p} !== {3'(k + 1), 3'(7 - k)}) begin
        failures++;
        $display("FAIL fail_piece%0d: seen=%0d piece=%0d/%0d, want %0d/%0d", k, seen, s, p, k + 1, 7 - k);
      end
      if (k == 5) pulse_score(4'd3, 1'b1, 1'b1);
      else pulse_score(4'd0, 1'b0, 1'b0);
    end
    checks++;
    if ({round_done, round_fail, round_score} !== {1'b1, 1'b1, 4'd3}) begin
      failures++;
      $display("FAIL fail_result: got rd=%b rf=%b rs=%0d, want 1 1 3", round_done, round_fail, round_score);
    end
    base = issue_count;
    for (int j = 0; j < 11; j++) push(3'(j % 8), 3'(7 - (j % 8)), ok);
    repeat (6) @(negedge clk);
    checks++;
    if (issue_count != base || dut.u_fifo.empty !== 1'b1) begin
      failures++;
      $display("FAIL drop_discard: issued=%0d empty=%b, want issued=0 empty=1", issue_count - base, dut.u_fifo.empty);
    end
    push(3'd6, 3'd4, ok);
    wait_issue(seen, s, p, n);
    checks++;
    if (!seen || {s, p} !== {3'd6, 3'd4}) begin
      failures++;
      $display("FAIL next_round_first: seen=%0d piece=%0d/%0d, want 6/4", seen, s, p);
    end
    @(negedge clk);
    checks++;
    if (dut.piece_cnt_r !== 5'd1) begin
      failures++;
      $display("FAIL next_round_count: got %0d, want 1", dut.piece_cnt_r);
    end
    pulse_score(4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    bit ok, seen;
    logic [2:0] s, p;
    int n;
    push(3'd2, 3'd3, ok);
    wait_issue(seen, s, p, n);
    checks++;
    if (!seen || {s, p} !== {3'd2, 3'd3}) begin
      failures++;
      $display("FAIL stall_issue: seen=%0d piece=%0d/%0d, want 2/3", seen, s, p);
    end
    repeat (900) @(negedge clk);
    checks++;
    if (stall_err !== 1'b0) begin
      failures++;
      $display("FAIL stall_early: got %b at 900 cycles, want 0", stall_err);
    end
    repeat (105) @(negedge clk);
    checks++;
    if (stall_err !== 1'b1) begin
      failures++;
      $display("FAIL stall_set: got %b after 1005 cycles, want 1", stall_err);
    end
    pulse_score(4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (stall_err !== 1'b1) begin
      failures++;
      $display("FAIL stall_sticky: got %b after late score, want 1", stall_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    logic [2:0] s, p;
    int n, base;
    push(3'd7, 3'd7, ok);
    wait_issue(seen, s, p, n);
    push(3'd1, 3'd2, ok);
    push(3'd2, 3'd4, ok);
    push(3'd3, 3'd6, ok);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_valid, tetrominoes, position, host_ready, round_done, round_fail, round_score, stall_err} !==
        {1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got iv=%b t=%0d p=%0d rdy=%b rd=%b rf=%b rs=%0d se=%b, want 0 0 0 1 0 0 0 0",
               in_valid, tetrominoes, position, host_ready, round_done, round_fail, round_score, stall_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = issue_count;
    repeat (6) @(negedge clk);
    checks++;
    if (issue_count != base || host_ready !== 1'b1) begin
      failures++;
      $display("FAIL fifo_cleared: issued=%0d rdy=%b, want issued=0 rdy=1", issue_count - base, host_ready);
    end
    push(3'd4, 3'd5, ok);
    wait_issue(seen, s, p, n);
    checks++;
    if (!seen || n != 1 || {s, p} !== {3'd4, 3'd5}) begin
      failures++;
      $display("FAIL post_reset_issue: seen=%0d ticks=%0d piece=%0d/%0d, want 1 1 4/5", seen, n, s, p);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    issue_count = 0;
    rst_n = 1'b0;
    host_valid = 1'b0;
    host_tetromino = 3'd0;
    host_position = 3'd0;
    score_valid = 1'b0;
    score = 4'd0;
    fail = 1'b0;
    tetris_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_round();
    test_fail_drop();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
